// File: rtl/multicycle_sequencer_if.sv
// Handshake/control bundle between the multicycle sequencer and its datapath/memories.
// master drives the request side; slave is the sequencer.
interface multicycle_sequencer_if #(
    parameter int unsigned COUNT_BITS = 32
);
    logic                  start;
    logic                  halt;
    logic [6:0]            opcode;
    logic                  i_valid;
    logic                  d_ready;
    logic                  rf_wEn_dec;
    logic                  mem_wEn_dec;

    logic                  i_req;
    logic                  ir_load;
    logic                  pc_wEn;
    logic                  rf_wEn;
    logic                  d_req;
    logic                  d_wEn;
    logic                  busy;
    logic                  fault;
    logic [2:0]            state;
    logic [COUNT_BITS-1:0] retired;

    modport master (
        output start, halt, opcode, i_valid, d_ready, rf_wEn_dec, mem_wEn_dec,
        input  i_req, ir_load, pc_wEn, rf_wEn, d_req, d_wEn, busy, fault, state, retired
    );

    modport slave (
        input  start, halt, opcode, i_valid, d_ready, rf_wEn_dec, mem_wEn_dec,
        output i_req, ir_load, pc_wEn, rf_wEn, d_req, d_wEn, busy, fault, state, retired
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM with memory timeouts.
// Define SEQ_RETIRE_COUNT_EN to build the retired-instruction counter; otherwise retired reads 0.
module multicycle_sequencer #(
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned COUNT_BITS = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    multicycle_sequencer_if.slave  bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_FAULT     = 3'd6;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;
    logic             legal_op;
    logic             i_req, ir_load, pc_wEn, rf_wEn, d_req, d_wEn;

    always_comb begin
        legal_op = 1'b0;
        case (bus.opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: legal_op = 1'b1;
            default:                           legal_op = 1'b0;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

    // Wait counter is zero everywhere except while stalled in FETCH/MEMORY, so it is clear on entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        i_req   = 1'b0;
        ir_load = 1'b0;
        pc_wEn  = 1'b0;
        rf_wEn  = 1'b0;
        d_req   = 1'b0;
        d_wEn   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                i_req = 1'b1;
                if (bus.i_valid) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                state_d = legal_op ? S_EXECUTE : S_FAULT;
            end
            S_EXECUTE: begin
                if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) begin
                    state_d = S_MEMORY;
                end else if (bus.opcode == OP_BRANCH) begin
                    pc_wEn  = 1'b1;
                    state_d = bus.halt ? S_IDLE : S_FETCH;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                d_req = 1'b1;
                d_wEn = bus.mem_wEn_dec;
                if (bus.d_ready) begin
                    if (bus.opcode == OP_LOAD) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        pc_wEn  = 1'b1;
                        state_d = bus.halt ? S_IDLE : S_FETCH;
                    end
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                rf_wEn  = bus.rf_wEn_dec;
                pc_wEn  = 1'b1;
                state_d = bus.halt ? S_IDLE : S_FETCH;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [COUNT_BITS-1:0] retired_q;

`ifdef SEQ_RETIRE_COUNT_EN
    logic [COUNT_BITS-1:0] retired_d;

    assign retired_d = pc_wEn ? retired_q + 1'b1 : retired_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end
`else
    assign retired_q = '0;
`endif

    // Gating by reset keeps every output at 0 for the whole time reset is held low.
    assign bus.i_req   = reset & i_req;
    assign bus.ir_load = reset & ir_load;
    assign bus.pc_wEn  = reset & pc_wEn;
    assign bus.rf_wEn  = reset & rf_wEn;
    assign bus.d_req   = reset & d_req;
    assign bus.d_wEn   = reset & d_wEn;
    assign bus.busy    = reset & (state_q != S_IDLE);
    assign bus.fault   = reset & (state_q == S_FAULT);
    assign bus.state   = reset ? state_q : S_IDLE;
    assign bus.retired = reset ? retired_q : '0;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer (TIMEOUT=15, COUNT_BITS=4).
module tb_multicycle_sequencer;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    // {i_req, ir_load, pc_wEn, rf_wEn, d_req, d_wEn, busy, fault}
    localparam logic [7:0] O_IDLE     = 8'b0000_0000;
    localparam logic [7:0] O_FETCH_HS = 8'b1100_0010;
    localparam logic [7:0] O_FETCH_W  = 8'b1000_0010;
    localparam logic [7:0] O_BUSY     = 8'b0000_0010;
    localparam logic [7:0] O_WB       = 8'b0011_0010;
    localparam logic [7:0] O_MEM_RD   = 8'b0000_1010;
    localparam logic [7:0] O_MEM_WR   = 8'b0000_1110;
    localparam logic [7:0] O_MEM_WRD  = 8'b0010_1110;
    localparam logic [7:0] O_BR       = 8'b0010_0010;
    localparam logic [7:0] O_FAULT    = 8'b0000_0011;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   nret     = 0;

    multicycle_sequencer_if #(.COUNT_BITS(4)) bus ();

    multicycle_sequencer #(.TIMEOUT(15), .COUNT_BITS(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] outs;
    assign outs = {bus.i_req, bus.ir_load, bus.pc_wEn, bus.rf_wEn,
                   bus.d_req, bus.d_wEn, bus.busy, bus.fault};

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ret_model(input int n);
        logic [31:0] m;
        m = 32'(n % 16);
`ifndef SEQ_RETIRE_COUNT_EN
        m = '0;
`endif
        return m;
    endfunction

    task automatic check_ret(input string tag);
        check({tag, ".retired"}, 32'(bus.retired), ret_model(nret));
    endtask

    task automatic drive(input logic s, input logic h, input logic [6:0] op,
                         input logic iv, input logic dr, input logic rfd, input logic mwd);
        bus.start       = s;
        bus.halt        = h;
        bus.opcode      = op;
        bus.i_valid     = iv;
        bus.d_ready     = dr;
        bus.rf_wEn_dec  = rfd;
        bus.mem_wEn_dec = mwd;
    endtask

    // Called just after a falling edge: check settled outputs, then advance one cycle.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [7:0] o);
        #1;
        check({tag, ".state"}, 32'(bus.state), 32'(st));
        check({tag, ".out"}, 32'(outs), 32'(o));
        @(negedge clock);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, ".rst_state"}, 32'(bus.state), 32'd0);
        check({tag, ".rst_out"}, 32'(outs), 32'(O_IDLE));
        nret = 0;
        check_ret(tag);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, OP_R, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("por.state", 32'(bus.state), 32'd0);
        check("por.out", 32'(outs), 32'(O_IDLE));
        check_ret("por");
        @(negedge clock);
        reset = 1'b1;

        // R-type, zero-wait memories, halt in writeback
        drive(1'b1, 1'b0, OP_R, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("r.idle", 3'd0, O_IDLE);
        bus.start = 1'b0;
        cyc("r.fetch", 3'd1, O_FETCH_HS);
        cyc("r.dec", 3'd2, O_BUSY);
        cyc("r.ex", 3'd3, O_BUSY);
        bus.halt = 1'b1;
        cyc("r.wb", 3'd5, O_WB);
        nret++;
        cyc("r.end", 3'd0, O_IDLE);
        check_ret("r");

        // LOAD with d_ready delayed three cycles
        drive(1'b1, 1'b0, OP_LOAD, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("ld.idle", 3'd0, O_IDLE);
        bus.start = 1'b0;
        cyc("ld.fetch", 3'd1, O_FETCH_HS);
        cyc("ld.dec", 3'd2, O_BUSY);
        cyc("ld.ex", 3'd3, O_BUSY);
        for (int i = 0; i < 3; i++) cyc("ld.memwait", 3'd4, O_MEM_RD);
        bus.d_ready = 1'b1;
        cyc("ld.memdone", 3'd4, O_MEM_RD);
        bus.d_ready = 1'b0;
        bus.halt    = 1'b1;
        cyc("ld.wb", 3'd5, O_WB);
        nret++;
        cyc("ld.end", 3'd0, O_IDLE);
        check_ret("ld");

        // STORE: rf_wEn_dec deliberately high to show it is gated off
        drive(1'b1, 1'b0, OP_STORE, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc("st.idle", 3'd0, O_IDLE);
        bus.start = 1'b0;
        cyc("st.fetch", 3'd1, O_FETCH_HS);
        cyc("st.dec", 3'd2, O_BUSY);
        cyc("st.ex", 3'd3, O_BUSY);
        bus.halt = 1'b1;
        cyc("st.mem", 3'd4, O_MEM_WRD);
        nret++;
        cyc("st.end", 3'd0, O_IDLE);
        check_ret("st");

        // BRANCH with halt held the whole time
        drive(1'b1, 1'b1, OP_BR, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc("br.idle", 3'd0, O_IDLE);
        bus.start = 1'b0;
        cyc("br.fetch", 3'd1, O_FETCH_HS);
        cyc("br.dec", 3'd2, O_BUSY);
        cyc("br.ex", 3'd3, O_BR);
        nret++;
        cyc("br.end", 3'd0, O_IDLE);
        check_ret("br");

        // i_valid arrives on the 16th fetch cycle: handshake beats the timeout
        drive(1'b1, 1'b0, OP_R, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("tr.idle", 3'd0, O_IDLE);
        bus.start = 1'b0;
        for (int i = 0; i < 15; i++) cyc("tr.wait", 3'd1, O_FETCH_W);
        bus.i_valid = 1'b1;
        cyc("tr.fetch16", 3'd1, O_FETCH_HS);
        cyc("tr.dec", 3'd2, O_BUSY);
        cyc("tr.ex", 3'd3, O_BUSY);
        bus.halt = 1'b1;
        cyc("tr.wb", 3'd5, O_WB);
        nret++;
        cyc("tr.end", 3'd0, O_IDLE);
        check_ret("tr");

        // i_valid withheld: FAULT after the 16th fetch cycle, sticky through start
        drive(1'b1, 1'b0, OP_R, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("to.idle", 3'd0, O_IDLE);
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) cyc("to.wait", 3'd1, O_FETCH_W);
        bus.start = 1'b1;
        cyc("to.fault", 3'd6, O_FAULT);
        bus.start = 1'b0;
        cyc("to.sticky", 3'd6, O_FAULT);
        check_ret("to.fault");
        do_reset("to");
        cyc("to.after", 3'd0, O_IDLE);

        // Illegal opcode faults out of DECODE
        drive(1'b1, 1'b0, OP_BAD, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc("il.idle", 3'd0, O_IDLE);
        bus.start = 1'b0;
        cyc("il.fetch", 3'd1, O_FETCH_HS);
        cyc("il.dec", 3'd2, O_BUSY);
        bus.start = 1'b1;
        cyc("il.fault", 3'd6, O_FAULT);
        bus.start = 1'b0;
        cyc("il.sticky", 3'd6, O_FAULT);
        do_reset("il");
        cyc("il.after", 3'd0, O_IDLE);

        // Reset pulled mid-MEMORY during a waiting STORE
        drive(1'b1, 1'b0, OP_STORE, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("mr.idle", 3'd0, O_IDLE);
        bus.start = 1'b0;
        cyc("mr.fetch", 3'd1, O_FETCH_HS);
        cyc("mr.dec", 3'd2, O_BUSY);
        cyc("mr.ex", 3'd3, O_BUSY);
        #1;
        check("mr.mem.state", 32'(bus.state), 32'd4);
        check("mr.mem.out", 32'(outs), 32'(O_MEM_WR));
        #1;
        do_reset("mr");
        bus.d_ready = 1'b1;
        cyc("mr.after", 3'd0, O_IDLE);

        // 16 back-to-back branches: the 4-bit counter wraps to 0
        drive(1'b1, 1'b0, OP_BR, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("wr.idle", 3'd0, O_IDLE);
        bus.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cyc("wr.fetch", 3'd1, O_FETCH_HS);
            cyc("wr.dec", 3'd2, O_BUSY);
            bus.halt = (k == 15);
            cyc("wr.ex", 3'd3, O_BR);
            nret++;
            if (k == 14) check_ret("wr.15");
        end
        cyc("wr.end", 3'd0, O_IDLE);
        check_ret("wr.wrap");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
